// File: rtl/term_writer.sv
//-----------------------------------------------------------------------------
// term_writer
//
// Byte-stream terminal front end feeding the text engine's VRAM write port.
// Characters arrive over a valid/ready handshake. The block keeps a cursor
// over the COLS x ROWS visible grid, interprets a few control codes, and
// issues single-cycle writes into the 64x32 character buffer at address
// {row[4:0], col[5:0]}. This includes full-screen and single-line clears.
//
// Handshake: a byte is transferred on a rising edge where i_valid and
// o_ready are both high. The producer holds i_data stable while i_valid is
// high and o_ready is low. o_ready is only ever high in IDLE.
//
// Optional feature macro: TERM_TAB_EN
//   defined   : 0x09 advances the cursor to the next multiple-of-8 column,
//               wrapping to a new line (with line clear) past the last column.
//   undefined : 0x09 is ignored like other unused control codes.
//
// Ports:
//   i_clk         system clock (same clock as the VRAM A port)
//   i_rst         asynchronous active-high reset
//   i_data[7:0]   character byte
//   i_valid       i_data valid
//   o_ready       byte accepted on an edge where i_valid & o_ready
//   o_vram_addr   {row, col} write address
//   o_vram_data   write data
//   o_vram_ce     write strobe, one write per high cycle
//   o_cursor_x    current column
//   o_cursor_y    current row
//   o_busy        high while a clear (full screen or line) is in progress
//   o_dbg_state   current FSM state, for debug and checkers
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module term_writer #(
   parameter int          COLS  = 60,
   parameter int          ROWS  = 17,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_data,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [10:0] o_vram_addr,
   output logic [7:0]  o_vram_data,
   output logic        o_vram_ce,
   output logic [5:0]  o_cursor_x,
   output logic [4:0]  o_cursor_y,
   output logic        o_busy,
   output logic [1:0]  o_dbg_state
);

   localparam logic [1:0] S_CLRALL  = 2'd0;
   localparam logic [1:0] S_IDLE    = 2'd1;
   localparam logic [1:0] S_WRITE   = 2'd2;
   localparam logic [1:0] S_CLRLINE = 2'd3;

   localparam logic [5:0] LAST_COL = 6'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   logic [1:0]  state;
   logic [10:0] sweep_cnt;
   logic        nl_pend;     // a newline (line clear) follows the WRITE cycle
   logic        hs;
   logic [4:0]  next_row;

   assign o_dbg_state = state;

   // o_ready is only raised in IDLE, so this is the accept condition.
   assign hs       = i_valid & o_ready;
   assign next_row = (o_cursor_y == LAST_ROW) ? 5'd0 : o_cursor_y + 5'd1;

`ifdef TERM_TAB_EN
   logic [6:0] tab_x;
   logic       tab_wrap;
   assign tab_x    = {1'b0, o_cursor_x | 6'd7} + 7'd1;
   assign tab_wrap = (tab_x >= 7'(COLS));
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= S_CLRALL;
         sweep_cnt   <= 11'd0;
         nl_pend     <= 1'b0;
         o_cursor_x  <= 6'd0;
         o_cursor_y  <= 5'd0;
         o_vram_ce   <= 1'b0;
         o_vram_addr <= 11'd0;
         o_vram_data <= 8'd0;
         o_ready     <= 1'b0;
         o_busy      <= 1'b1;
      end else begin
         case (state)
            S_CLRALL: begin
               o_vram_ce   <= 1'b1;
               o_vram_addr <= sweep_cnt;
               o_vram_data <= BLANK;
               o_ready     <= 1'b0;
               o_busy      <= 1'b1;
               sweep_cnt   <= sweep_cnt + 11'd1;
               if (sweep_cnt == 11'h7FF) begin
                  // Last write is in flight; IDLE raises ready one edge later.
                  state      <= S_IDLE;
                  sweep_cnt  <= 11'd0;
                  o_cursor_x <= 6'd0;
                  o_cursor_y <= 5'd0;
               end
            end

            S_CLRLINE: begin
               o_vram_ce   <= 1'b1;
               o_vram_addr <= {o_cursor_y, sweep_cnt[5:0]};
               o_vram_data <= BLANK;
               o_ready     <= 1'b0;
               o_busy      <= 1'b1;
               sweep_cnt   <= sweep_cnt + 11'd1;
               if (sweep_cnt[5:0] == 6'h3F) begin
                  state     <= S_IDLE;
                  sweep_cnt <= 11'd0;
               end
            end

            S_WRITE: begin
               o_vram_ce <= 1'b0;
               if (nl_pend) begin
                  nl_pend   <= 1'b0;
                  state     <= S_CLRLINE;
                  sweep_cnt <= 11'd0;
                  o_busy    <= 1'b1;
                  o_ready   <= 1'b0;
               end else begin
                  state   <= S_IDLE;
                  o_ready <= 1'b1;
               end
            end

            default: begin // S_IDLE
               o_vram_ce <= 1'b0;
               o_ready   <= 1'b1;
               o_busy    <= 1'b0;
               if (hs) begin
                  if (i_data >= 8'h20) begin
                     o_vram_ce   <= 1'b1;
                     o_vram_addr <= {o_cursor_y, o_cursor_x};
                     o_vram_data <= i_data;
                     o_ready     <= 1'b0;
                     state       <= S_WRITE;
                     if (o_cursor_x == LAST_COL) begin
                        // Character lands first; the line clear follows WRITE.
                        o_cursor_x <= 6'd0;
                        o_cursor_y <= next_row;
                        nl_pend    <= 1'b1;
                     end else begin
                        o_cursor_x <= o_cursor_x + 6'd1;
                     end
                  end else begin
                     case (i_data)
                        8'h0D: o_cursor_x <= 6'd0;
                        8'h0A: begin
                           o_cursor_x <= 6'd0;
                           o_cursor_y <= next_row;
                           state      <= S_CLRLINE;
                           sweep_cnt  <= 11'd0;
                           o_ready    <= 1'b0;
                           o_busy     <= 1'b1;
                        end
                        8'h08: begin
                           if (o_cursor_x != 6'd0) begin
                              o_cursor_x  <= o_cursor_x - 6'd1;
                              o_vram_ce   <= 1'b1;
                              o_vram_addr <= {o_cursor_y, o_cursor_x - 6'd1};
                              o_vram_data <= BLANK;
                              o_ready     <= 1'b0;
                              state       <= S_WRITE;
                           end
                        end
                        8'h0C: begin
                           o_cursor_x <= 6'd0;
                           o_cursor_y <= 5'd0;
                           state      <= S_CLRALL;
                           sweep_cnt  <= 11'd0;
                           o_ready    <= 1'b0;
                           o_busy     <= 1'b1;
                        end
`ifdef TERM_TAB_EN
                        8'h09: begin
                           if (tab_wrap) begin
                              o_cursor_x <= 6'd0;
                              o_cursor_y <= next_row;
                              state      <= S_CLRLINE;
                              sweep_cnt  <= 11'd0;
                              o_ready    <= 1'b0;
                              o_busy     <= 1'b1;
                           end else begin
                              o_cursor_x <= tab_x[5:0];
                           end
                        end
`endif
                        default: ; // unused control codes are dropped
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_term_writer.sv
//-----------------------------------------------------------------------------
// tb_term_writer
//
// Drives term_writer with bytes through a driver task that keeps a cursor
// model and pushes every expected VRAM write ({addr, data}) onto exp_q when
// the byte is offered. A negedge monitor pops and compares on each o_vram_ce.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_term_writer;

   localparam int COLS = 60;
   localparam int ROWS = 17;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [7:0]  i_data = 8'd0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [10:0] o_vram_addr;
   logic [7:0]  o_vram_data;
   logic        o_vram_ce;
   logic [5:0]  o_cursor_x;
   logic [4:0]  o_cursor_y;
   logic        o_busy;
   logic [1:0]  o_dbg_state;

   term_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_data      (i_data),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .o_vram_addr (o_vram_addr),
      .o_vram_data (o_vram_data),
      .o_vram_ce   (o_vram_ce),
      .o_cursor_x  (o_cursor_x),
      .o_cursor_y  (o_cursor_y),
      .o_busy      (o_busy),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 i_clk = ~i_clk;

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [18:0] exp_q[$];
   logic [18:0] mon_e;
   int          mx = 0;
   int          my = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input int r, input int c, input logic [7:0] d);
      exp_q.push_back({r[4:0], c[5:0], d});
   endtask

   task automatic push_all();
      for (int a = 0; a < 2048; a++) exp_q.push_back({a[10:0], 8'h20});
   endtask

   task automatic model_newline();
      my = (my == ROWS - 1) ? 0 : my + 1;
      for (int c = 0; c < 64; c++) push_wr(my, c, 8'h20);
   endtask

   // ---------------- monitor ----------------
   always @(negedge i_clk) begin
      if (!i_rst && o_vram_ce) begin
         check("ce_rdy", 32'(o_ready), 32'd0);
         if (exp_q.size() == 0) begin
            check("extra_write", 32'(o_vram_ce), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("vram_wr", {13'd0, o_vram_addr, o_vram_data}, {13'd0, mon_e});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b, input bit hold);
      int  n;
      bit  wr;
      bit  stay;
      @(negedge i_clk);
      i_data  = b;
      i_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 5000) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_ready) begin
         check("rdy_timeout", 32'(o_ready), 32'd1);
         i_valid = 1'b0;
         return;
      end
      wr   = 1'b0;
      stay = 1'b0;
      if (b >= 8'h20) begin
         push_wr(my, mx, b);
         wr = 1'b1;
         if (mx == COLS - 1) begin
            mx = 0;
            model_newline();
         end else begin
            mx++;
         end
      end else begin
         case (b)
            8'h0D: begin mx = 0; stay = 1'b1; end
            8'h0A: begin mx = 0; model_newline(); end
            8'h08: begin
               if (mx > 0) begin
                  mx--;
                  push_wr(my, mx, 8'h20);
                  wr = 1'b1;
               end else begin
                  stay = 1'b1;
               end
            end
            8'h0C: begin mx = 0; my = 0; push_all(); end
`ifdef TERM_TAB_EN
            8'h09: begin
               mx = (mx | 7) + 1;
               if (mx >= COLS) begin
                  mx = 0;
                  model_newline();
               end else begin
                  stay = 1'b1;
               end
            end
`endif
            default: stay = 1'b1;
         endcase
      end
      @(posedge i_clk);
      @(negedge i_clk);
      if (!hold) i_valid = 1'b0;
      check("cur_x", 32'(o_cursor_x), 32'(mx));
      check("cur_y", 32'(o_cursor_y), 32'(my));
      if (wr) check("wr_lat", 32'(o_vram_ce), 32'd1);
      check("rdy_after", 32'(o_ready), stay ? 32'd1 : 32'd0);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !o_ready) && n < 6000) begin
         @(negedge i_clk);
         n++;
      end
      check(tag, 32'(exp_q.size()), 32'd0);
      check({tag, "_rdy"}, 32'(o_ready), 32'd1);
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ce"},   32'(o_vram_ce),   32'd0);
      check({tag, "_rdy"},  32'(o_ready),     32'd0);
      check({tag, "_busy"}, 32'(o_busy),      32'd1);
      check({tag, "_addr"}, 32'(o_vram_addr), 32'd0);
      check({tag, "_data"}, 32'(o_vram_data), 32'd0);
      check({tag, "_cx"},   32'(o_cursor_x),  32'd0);
      check({tag, "_cy"},   32'(o_cursor_y),  32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int pick;
      logic [7:0] rb;

      // Reset and power-on clear.
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      check_reset_vals("rst");
      push_all();
      i_rst = 1'b0;
      @(negedge i_clk);
      check("first_ce", 32'(o_vram_ce), 32'd1);
      wait_drain("clrall0");
      check("cx_post_clr", 32'(o_cursor_x), 32'd0);
      check("cy_post_clr", 32'(o_cursor_y), 32'd0);

      // Single character, then CR back to column 0.
      send_byte(8'h41, 1'b0);
      send_byte(8'h0D, 1'b0);

      // Full line with i_valid held high: wraps and clears row 1.
      for (int i = 0; i < COLS; i++) send_byte(8'h41, 1'b1);
      i_valid = 1'b0;
      wait_drain("line_wrap");

      // Move to (7,16) and LF: wrap to row 0, clear row 0.
      for (int i = 0; i < 15; i++) send_byte(8'h0A, 1'b0);
      for (int i = 0; i < 7; i++) send_byte(8'h42, 1'b0);
      send_byte(8'h0A, 1'b0);
      wait_drain("lf_wrap");

      // Backspace at (5,2) and at (0,2).
      send_byte(8'h0A, 1'b0);
      send_byte(8'h0A, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(8'h43, 1'b0);
      send_byte(8'h08, 1'b0);
      send_byte(8'h0D, 1'b0);
      send_byte(8'h08, 1'b0);

      // Tab from column 3 and from column 58; ignored control codes.
      for (int i = 0; i < 3; i++) send_byte(8'h44, 1'b0);
      send_byte(8'h09, 1'b0);
      send_byte(8'h0D, 1'b0);
      for (int i = 0; i < 58; i++) send_byte(8'h45, 1'b0);
      send_byte(8'h09, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h1F, 1'b0);
      send_byte(8'hFF, 1'b0);
      wait_drain("tab");

      // Form feed: full clear, cursor home.
      send_byte(8'h0C, 1'b0);
      check("ff_busy", 32'(o_busy), 32'd1);
      wait_drain("ff");

      // Random mix.
      for (int i = 0; i < 60; i++) begin
         pick = $urandom_range(0, 9);
         case (pick)
            6: rb = 8'h0D;
            7: rb = 8'h0A;
            8: rb = 8'h08;
            9: rb = ($urandom_range(0, 1) == 0) ? 8'h09 : 8'h1B;
            default: rb = 8'($urandom_range(32, 255));
         endcase
         send_byte(rb, 1'b0);
      end
      wait_drain("rand");

      // Reset in the middle of a line clear: sweep restarts from 0x000.
      send_byte(8'h0A, 1'b0);
      repeat (20) @(negedge i_clk);
      #2;
      i_rst = 1'b1;
      exp_q.delete();
      mx = 0;
      my = 0;
      repeat (2) @(negedge i_clk);
      check_reset_vals("midrst");
      push_all();
      i_rst = 1'b0;
      @(negedge i_clk);
      check("first_ce2", 32'(o_vram_ce), 32'd1);
      wait_drain("clrall1");

      // Quiet period: any stray write is caught by the monitor.
      repeat (20) @(negedge i_clk);
      check("end_q", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
